// File: rtl/fc.sv
`timescale 1ns/1ps
// Fibre Channel receive-side primitive codes and the ordered-set decode table.
package fc;

  typedef enum logic [2:0] {
    PRIM_NONE  = 3'd0,
    PRIM_IDLE  = 3'd1,
    PRIM_R_RDY = 3'd2,
    PRIM_OLS   = 3'd3,
    PRIM_NOS   = 3'd4,
    PRIM_LR    = 3'd5,
    PRIM_LRR   = 3'd6,
    PRIM_OTHER = 3'd7
  } primitive_t;

  // K28.5-led ordered sets, byte 3 is the first transmitted character.
  function automatic primitive_t map_primitive(input logic [31:0] w);
    primitive_t p;
    case (w)
      32'hBC95_B5B5: p = PRIM_IDLE;
      32'hBC95_4A4A: p = PRIM_R_RDY;
      32'hBC35_8A55: p = PRIM_OLS;
      32'hBC55_BF45: p = PRIM_NOS;
      32'hBC49_BF49: p = PRIM_LR;
      32'hBC35_BF49: p = PRIM_LRR;
      default:       p = PRIM_OTHER;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/fc_prim_qualify_if.sv
`timescale 1ns/1ps
// Word stream in / qualified primitive out bundle for fc_prim_qualify.
interface fc_prim_qualify_if;
  logic [31:0]      data;
  logic [3:0]       datak;
  logic             err_clear;
  fc::primitive_t   prim;
  logic             prim_valid;
  logic             prim_new;
  logic [15:0]      err_count;

  modport master (
    output data, datak, err_clear,
    input  prim, prim_valid, prim_new, err_count
  );

  modport slave (
    input  data, datak, err_clear,
    output prim, prim_valid, prim_new, err_count
  );
endinterface

// File: rtl/fc_prim_qualify.sv
`timescale 1ns/1ps
// Receive primitive qualifier: stage 1 classifies each word, stage 2 runs the
// HUNT/COUNT/QUAL run-length FSM and the illegal-K error counter.
module fc_prim_qualify #(
    parameter int unsigned SEQ_THRESHOLD  = 3,
    parameter int unsigned IDLE_THRESHOLD = 1
) (
    input  logic              clk,
    input  logic              reset,
    fc_prim_qualify_if.slave  bus
);
    import fc::*;

    typedef enum logic [2:0] {CLS_DATA, CLS_OTHER, CLS_ILL, CLS_SEQ, CLS_IDLE} cls_t;
    typedef enum logic [1:0] {HUNT, COUNT, QUAL} state_t;

    localparam logic [3:0] SEQ_THR  = 4'(SEQ_THRESHOLD);
    localparam logic [3:0] IDLE_THR = 4'(IDLE_THRESHOLD);

    // ---------------- stage 1: classification ----------------
    primitive_t w_code;
    cls_t       w_cls;

    assign w_code = map_primitive(bus.data);

    always_comb begin
        w_cls = CLS_ILL;
        if (bus.datak == 4'b0000) begin
            w_cls = CLS_DATA;
        end else if (bus.datak == 4'b1000) begin
            w_cls = CLS_OTHER;
            if (bus.data[31:24] == 8'hBC) begin
                case (w_code)
                    PRIM_OLS, PRIM_NOS, PRIM_LR, PRIM_LRR: w_cls = CLS_SEQ;
                    PRIM_IDLE:                             w_cls = CLS_IDLE;
                    default:                               w_cls = CLS_OTHER;
                endcase
            end
        end
    end

    cls_t       r_s1_cls;
    primitive_t r_s1_code;
    logic       r_s1_clr;

    // err_clear travels with its word so clear and a same-cycle illegal word meet in stage 2.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_cls  <= CLS_DATA;
            r_s1_code <= PRIM_NONE;
            r_s1_clr  <= 1'b0;
        end else begin
            r_s1_cls  <= w_cls;
            r_s1_code <= w_code;
            r_s1_clr  <= bus.err_clear;
        end
    end

    // ---------------- stage 2: qualification FSM ----------------
    state_t     r_state, w_state_nx;
    logic [3:0] r_run,   w_run_nx;
    primitive_t r_last,  w_last_nx;
    primitive_t r_prim,  w_prim_nx;
    logic       r_new,   w_new_nx;
    logic [3:0] w_thr;
    logic       w_qword;

    assign w_qword = (r_s1_cls == CLS_SEQ) || (r_s1_cls == CLS_IDLE);
    assign w_thr   = (r_s1_cls == CLS_IDLE) ? IDLE_THR : SEQ_THR;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= HUNT;
            r_run   <= 4'd0;
            r_last  <= PRIM_NONE;
            r_prim  <= PRIM_NONE;
            r_new   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_run   <= w_run_nx;
            r_last  <= w_last_nx;
            r_prim  <= w_prim_nx;
            r_new   <= w_new_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_run_nx   = r_run;
        w_last_nx  = r_last;
        w_prim_nx  = r_prim;
        w_new_nx   = 1'b0;
        if (!w_qword) begin
            w_state_nx = HUNT;
            w_run_nx   = 4'd0;
        end else if (r_state == HUNT || r_s1_code != r_last) begin
            w_last_nx  = r_s1_code;
            w_run_nx   = 4'd1;
            w_state_nx = (w_thr == 4'd1) ? QUAL : COUNT;
        end else begin
            if (r_run < w_thr)
                w_run_nx = r_run + 4'd1;
            w_state_nx = (w_run_nx >= w_thr) ? QUAL : COUNT;
        end
        if (w_state_nx == QUAL) begin
            w_prim_nx = w_last_nx;
            // Covers both a fresh qualification and a direct code swap at threshold 1.
            w_new_nx  = (r_state != QUAL) || (w_last_nx != r_prim);
        end
    end

    // ---------------- illegal-K error counter ----------------
    logic [15:0] r_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_err <= 16'd0;
        else if (r_s1_clr)
            r_err <= 16'd0;
        else if (r_s1_cls == CLS_ILL && r_err != 16'hFFFF)
            r_err <= r_err + 16'd1;
    end

    assign bus.prim       = r_prim;
    assign bus.prim_valid = (r_state == QUAL);
    assign bus.prim_new   = r_new;
    assign bus.err_count  = r_err;

endmodule
